// File: rtl/adc_spi_rx.sv
// SPI receiver for a serial ADC: starts a conversion every sample_period clocks,
// clocks out lead_bits + datlen SCLK periods and presents the datlen data bits MSB-first.
module adc_spi_rx #(
    parameter int unsigned datlen        = 12,
    parameter int unsigned lead_bits     = 3,
    parameter int unsigned clk_div       = 2,
    parameter int unsigned sample_period = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              adc_miso,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    output logic [0:datlen-1] sample,
    output logic              sample_valid,
    output logic              overrun
);

    localparam int unsigned NBits = lead_bits + datlen;
    localparam int unsigned PerW  = $clog2(sample_period + 1);
    localparam int unsigned DivW  = $clog2(clk_div + 1);
    localparam int unsigned BitW  = $clog2(NBits + 1);

    localparam logic [PerW-1:0] PerLast = PerW'(sample_period - 1);
    localparam logic [DivW-1:0] DivLast = DivW'(clk_div - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(NBits - 1);
    localparam logic [BitW-1:0] LeadCnt = BitW'(lead_bits);

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

    state_e            state_q, state_d;
    logic [PerW-1:0]   per_q, per_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic              cs_n_q, cs_n_d;
    logic              sclk_q, sclk_d;
    logic [0:datlen-1] shreg_q, shreg_d;
    logic [0:datlen-1] sample_q, sample_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              tick;

    assign tick = (per_q == PerLast);

    always_comb begin
        state_d   = state_q;
        per_d     = tick ? '0 : per_q + 1'b1;
        div_d     = div_q;
        bit_d     = bit_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        shreg_d   = shreg_q;
        sample_d  = sample_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;

        // A start request that finds the converter busy is lost, not queued.
        if (tick && state_q != StIdle) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (tick && enable) begin
                    state_d = StSetup;
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            StSetup: begin
                if (div_q == DivLast) begin
                    state_d = StShift;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StShift: begin
                if (div_q == DivLast) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        // Leading sampling/null bits are never shifted in.
                        if (bit_q >= LeadCnt) begin
                            shreg_d = {shreg_q[1:datlen-1], adc_miso};
                        end
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == BitLast) begin
                            state_d = StHold;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StHold: begin
                if (div_q == DivLast) begin
                    state_d  = StIdle;
                    cs_n_d   = 1'b1;
                    sample_d = shreg_q;
                    valid_d  = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            per_q     <= '0;
            div_q     <= '0;
            bit_q     <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            shreg_q   <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_q     <= per_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            shreg_q   <= shreg_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign adc_cs_n     = cs_n_q;
    assign adc_sclk     = sclk_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_spi_rx.sv
// Directed bench for adc_spi_rx: three instances (default timing, short period, clk_div=1)
// each fed by a behavioural ADC that shifts a 15-bit word out on SCLK falling edges.
module tb_adc_spi_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        en       [3];
    logic        miso     [3];
    logic        cs_w     [3];
    logic        sclk_w   [3];
    logic        valid_w  [3];
    logic        ovr_w    [3];
    logic [0:11] smp_w    [3];
    logic [14:0] word     [3];
    int          idx_m    [3];
    logic        prev_s   [3];

    int total = 0;
    int bad   = 0;

    adc_spi_rx #(.datlen(12), .lead_bits(3), .clk_div(2), .sample_period(100)) u_a (
        .clk(clk), .rst(rst), .enable(en[0]), .adc_miso(miso[0]), .adc_cs_n(cs_w[0]),
        .adc_sclk(sclk_w[0]), .sample(smp_w[0]), .sample_valid(valid_w[0]), .overrun(ovr_w[0])
    );
    adc_spi_rx #(.datlen(12), .lead_bits(3), .clk_div(2), .sample_period(40)) u_b (
        .clk(clk), .rst(rst), .enable(en[1]), .adc_miso(miso[1]), .adc_cs_n(cs_w[1]),
        .adc_sclk(sclk_w[1]), .sample(smp_w[1]), .sample_valid(valid_w[1]), .overrun(ovr_w[1])
    );
    adc_spi_rx #(.datlen(12), .lead_bits(3), .clk_div(1), .sample_period(100)) u_c (
        .clk(clk), .rst(rst), .enable(en[2]), .adc_miso(miso[2]), .adc_cs_n(cs_w[2]),
        .adc_sclk(sclk_w[2]), .sample(smp_w[2]), .sample_valid(valid_w[2]), .overrun(ovr_w[2])
    );

    // ADC model: first bit valid after CS falls, next bit after each SCLK falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (cs_w[i]) idx_m[i] = 0;
            else if (prev_s[i] && !sclk_w[i]) idx_m[i] = idx_m[i] + 1;
            prev_s[i] = sclk_w[i];
            miso[i] = (idx_m[i] < 15) ? word[i][14 - idx_m[i]] : 1'b0;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) en[i] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_fall(input int i, output int w);
        w = 0;
        while (cs_w[i] && w < 400) begin
            @(negedge clk);
            w++;
        end
    endtask

    // w: cycles until CS falls, l: cycles CS low, nv: valid pulses, nh: SCLK-high cycles.
    task automatic measure(input int i, output int w, output int l, output int nv,
                           output int nh);
        w = 0; l = 0; nv = 0; nh = 0;
        while (cs_w[i] && w < 400) begin
            @(negedge clk);
            w++;
            if (valid_w[i]) nv++;
        end
        while (!cs_w[i] && l < 400) begin
            @(negedge clk);
            l++;
            if (valid_w[i]) nv++;
            if (sclk_w[i]) nh++;
        end
    endtask

    task automatic test_reset();
        int w;
        word[0] = 15'h0A5C;
        do_reset();
        en[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++; if (cs_w[i] !== 1'b1) begin bad++; $display("FAIL reset_cs[%0d]: got %b want 1", i, cs_w[i]); end
            total++; if (sclk_w[i] !== 1'b0) begin bad++; $display("FAIL reset_sclk[%0d]: got %b want 0", i, sclk_w[i]); end
            total++; if (smp_w[i] !== 12'h000) begin bad++; $display("FAIL reset_sample[%0d]: got %h want 000", i, smp_w[i]); end
            total++; if (valid_w[i] !== 1'b0) begin bad++; $display("FAIL reset_valid[%0d]: got %b want 0", i, valid_w[i]); end
            total++; if (ovr_w[i] !== 1'b0) begin bad++; $display("FAIL reset_ovr[%0d]: got %b want 0", i, ovr_w[i]); end
        end
        rst = 1'b0;
        wait_fall(0, w);
        total++; if (w !== 100) begin bad++; $display("FAIL reset_first_tick: got %0d want 100", w); end
    endtask

    task automatic test_basic();
        int w, l, nv, nh;
        word[0] = {3'b000, 12'hA5C};
        do_reset();
        en[0] = 1'b1;
        rst = 1'b0;
        measure(0, w, l, nv, nh);
        total++; if (w !== 100) begin bad++; $display("FAIL basic_wait: got %0d want 100", w); end
        total++; if (l !== 64) begin bad++; $display("FAIL basic_low: got %0d want 64", l); end
        total++; if (nv !== 1) begin bad++; $display("FAIL basic_nvalid: got %0d want 1", nv); end
        total++; if (nh !== 30) begin bad++; $display("FAIL basic_sclk_high: got %0d want 30", nh); end
        total++; if (smp_w[0] !== 12'hA5C) begin bad++; $display("FAIL basic_sample: got %h want a5c", smp_w[0]); end
        word[0] = {3'b000, 12'h5A3};
        @(negedge clk);
        total++; if (valid_w[0] !== 1'b0) begin bad++; $display("FAIL basic_valid_width: got %b want 0", valid_w[0]); end
        repeat (50) @(negedge clk);
        total++; if (cs_w[0] !== 1'b0) begin bad++; $display("FAIL basic_second_busy: got %b want 0", cs_w[0]); end
        total++; if (smp_w[0] !== 12'hA5C) begin bad++; $display("FAIL basic_hold: got %h want a5c", smp_w[0]); end
        measure(0, w, l, nv, nh);
        total++; if (l !== 49) begin bad++; $display("FAIL basic_second_low: got %0d want 49", l); end
        total++; if (nv !== 1) begin bad++; $display("FAIL basic_second_nvalid: got %0d want 1", nv); end
        total++; if (smp_w[0] !== 12'h5A3) begin bad++; $display("FAIL basic_second_sample: got %h want 5a3", smp_w[0]); end
        total++; if (ovr_w[0] !== 1'b0) begin bad++; $display("FAIL basic_ovr: got %b want 0", ovr_w[0]); end
    endtask

    task automatic test_data();
        int w, l, nv, nh;
        word[0] = {3'b000, 12'hFFF};
        do_reset();
        en[0] = 1'b1;
        rst = 1'b0;
        measure(0, w, l, nv, nh);
        total++; if (smp_w[0] !== 12'hFFF) begin bad++; $display("FAIL data_fff: got %h want fff", smp_w[0]); end
        word[0] = {3'b111, 12'h000};
        measure(0, w, l, nv, nh);
        total++; if (w !== 36) begin bad++; $display("FAIL data_gap: got %0d want 36", w); end
        total++; if (smp_w[0] !== 12'h000) begin bad++; $display("FAIL data_000: got %h want 000", smp_w[0]); end
    endtask

    task automatic test_enable();
        int w, l, nv, nh, lows, vals;
        word[0] = {3'b000, 12'hA5C};
        do_reset();
        rst = 1'b0;
        lows = 0; vals = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (!cs_w[0]) lows++;
            if (valid_w[0]) vals++;
        end
        total++; if (lows !== 0) begin bad++; $display("FAIL en_off_cs: got %0d want 0", lows); end
        total++; if (vals !== 0) begin bad++; $display("FAIL en_off_valid: got %0d want 0", vals); end
        total++; if (ovr_w[0] !== 1'b0) begin bad++; $display("FAIL en_off_ovr: got %b want 0", ovr_w[0]); end
        en[0] = 1'b1;
        wait_fall(0, w);
        total++; if (w !== 50) begin bad++; $display("FAIL en_start: got %0d want 50", w); end
        repeat (10) @(negedge clk);
        en[0] = 1'b0;
        measure(0, w, l, nv, nh);
        total++; if (l !== 54) begin bad++; $display("FAIL en_drop_low: got %0d want 54", l); end
        total++; if (nv !== 1) begin bad++; $display("FAIL en_drop_nvalid: got %0d want 1", nv); end
        total++; if (smp_w[0] !== 12'hA5C) begin bad++; $display("FAIL en_drop_sample: got %h want a5c", smp_w[0]); end
        lows = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (!cs_w[0]) lows++;
        end
        total++; if (lows !== 0) begin bad++; $display("FAIL en_drop_idle: got %0d want 0", lows); end
    endtask

    task automatic test_overrun();
        int w, l, nv, nh;
        word[1] = {3'b000, 12'hA5C};
        do_reset();
        en[1] = 1'b1;
        rst = 1'b0;
        wait_fall(1, w);
        total++; if (w !== 40) begin bad++; $display("FAIL ovr_first_tick: got %0d want 40", w); end
        total++; if (ovr_w[1] !== 1'b0) begin bad++; $display("FAIL ovr_early: got %b want 0", ovr_w[1]); end
        measure(1, w, l, nv, nh);
        total++; if (l !== 64) begin bad++; $display("FAIL ovr_low: got %0d want 64", l); end
        total++; if (ovr_w[1] !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b want 1", ovr_w[1]); end
        total++; if (smp_w[1] !== 12'hA5C) begin bad++; $display("FAIL ovr_sample: got %h want a5c", smp_w[1]); end
        measure(1, w, l, nv, nh);
        total++; if (w !== 16) begin bad++; $display("FAIL ovr_alt_gap: got %0d want 16", w); end
        total++; if (nv !== 1) begin bad++; $display("FAIL ovr_alt_nvalid: got %0d want 1", nv); end
        total++; if (ovr_w[1] !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %b want 1", ovr_w[1]); end
    endtask

    task automatic test_reset_mid();
        int w, l, nv, nh;
        word[0] = {3'b000, 12'hA5C};
        do_reset();
        en[0] = 1'b1;
        rst = 1'b0;
        wait_fall(0, w);
        repeat (20) @(negedge clk);
        total++; if (sclk_w[0] !== 1'b1) begin bad++; $display("FAIL mid_sclk_pre: got %b want 1", sclk_w[0]); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (cs_w[0] !== 1'b1) begin bad++; $display("FAIL mid_cs: got %b want 1", cs_w[0]); end
        total++; if (sclk_w[0] !== 1'b0) begin bad++; $display("FAIL mid_sclk: got %b want 0", sclk_w[0]); end
        total++; if (valid_w[0] !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", valid_w[0]); end
        total++; if (smp_w[0] !== 12'h000) begin bad++; $display("FAIL mid_sample: got %h want 000", smp_w[0]); end
        rst = 1'b0;
        measure(0, w, l, nv, nh);
        total++; if (w !== 100) begin bad++; $display("FAIL mid_restart: got %0d want 100", w); end
        total++; if (nv !== 1) begin bad++; $display("FAIL mid_nvalid: got %0d want 1", nv); end
    endtask

    task automatic test_clkdiv1();
        int w, l, nv, nh;
        word[2] = {3'b000, 12'h3C5};
        do_reset();
        en[2] = 1'b1;
        rst = 1'b0;
        measure(2, w, l, nv, nh);
        total++; if (w !== 100) begin bad++; $display("FAIL div1_wait: got %0d want 100", w); end
        total++; if (l !== 32) begin bad++; $display("FAIL div1_low: got %0d want 32", l); end
        total++; if (nh !== 15) begin bad++; $display("FAIL div1_sclk_high: got %0d want 15", nh); end
        total++; if (smp_w[2] !== 12'h3C5) begin bad++; $display("FAIL div1_sample: got %h want 3c5", smp_w[2]); end
        word[2] = {3'b000, 12'hC3A};
        measure(2, w, l, nv, nh);
        total++; if (w !== 68) begin bad++; $display("FAIL div1_gap: got %0d want 68", w); end
        total++; if (smp_w[2] !== 12'hC3A) begin bad++; $display("FAIL div1_sample2: got %h want c3a", smp_w[2]); end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            en[i]     = 1'b0;
            word[i]   = '0;
            idx_m[i]  = 0;
            prev_s[i] = 1'b0;
            miso[i]   = 1'b0;
        end
        test_reset();
        test_basic();
        test_data();
        test_enable();
        test_overrun();
        test_reset_mid();
        test_clkdiv1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
